axi_stream_strip_header: RTL and testbench

// - Downstream companion of the header inserter. Removes the first N bytes of each AXI-Stream packet.
// - Realigns the remaining payload so every output beat is full except the last.
// - N per packet arrives on a separate length channel (s00). Typical source: a stream produced by the header inserter.
// - Byte order: MSB byte first. Non-last beats carry all bytes; the last beat's tkeep is contiguous from the MSB.

---
 rtl/axi_stream_strip_header.sv | 217 +++++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_strip_header
// Purpose  : Removes the first N bytes of each AXI-Stream packet and realigns
//            the remaining payload so that every output beat except the last
//            is full. N arrives per packet on a separate length channel.
//            Byte 0 of a beat occupies the MSB lane; tkeep bit B-1 is byte 0.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // strip-length channel
  input  logic                    s00_axis_tvalid,
  input  logic [LEN_WD-1:0]       s00_axis_tdata,
  output logic                    s00_axis_tready,
  // input packet channel
  input  logic                    s01_axis_tvalid,
  input  logic [DATA_WD-1:0]      s01_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  // output packet channel
  output logic                    m_axis_tvalid,
  output logic [DATA_WD-1:0]      m_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int RES_WD = (DATA_BYTE_WD > 1) ? $clog2(DATA_BYTE_WD) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DROP  = 3'd1,
    ALIGN = 3'd2,
    PASS  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t                  state;
  logic                    len_rdy;     // registered length-channel ready
  logic [LEN_WD-1:0]       drop_cnt;    // whole beats still to discard
  logic [RES_WD-1:0]       res;         // leading bytes to strip from first kept beat
  logic [DATA_WD-1:0]      hold;        // previous input beat (its low B-R bytes are pending)
  logic [DATA_BYTE_WD-1:0] flush_keep;  // keep of the trailing flush beat

  logic                    out_free;
  logic                    in_ready;
  logic                    in_fire;
  logic [LEN_WD-1:0]       len_d;
  logic [RES_WD-1:0]       len_r;
  logic [DATA_BYTE_WD-1:0] keep_eff;
  logic [DATA_BYTE_WD-1:0] keep_shl;
  logic [DATA_BYTE_WD-1:0] pass_keep;
  logic [DATA_WD-1:0]      in_shl;
  logic [DATA_WD-1:0]      pass_data;
  logic [DATA_WD-1:0]      flush_data;

  assign out_free        = !m_axis_tvalid || m_axis_tready;
  assign in_fire         = s01_axis_tvalid && in_ready;
  assign s01_axis_tready = in_ready;
  assign s00_axis_tready = len_rdy;

  // Input ready: DROP never emits; ALIGN/PASS may emit, so they wait for a free output register
  always_comb begin
    in_ready = 1'b0;
    case (state)
      DROP:        in_ready = 1'b1;
      ALIGN, PASS: in_ready = out_free;
      default:     in_ready = 1'b0;
    endcase
  end

  // Realignment datapath: split N, and build the shifted data/keep candidates
  always_comb begin
    len_d      = LEN_WD'(s00_axis_tdata / DATA_BYTE_WD);
    len_r      = RES_WD'(s00_axis_tdata % DATA_BYTE_WD);
    // only the last beat may carry a partial keep; earlier beats count as full
    keep_eff   = s01_axis_tlast ? s01_axis_tkeep : {DATA_BYTE_WD{1'b1}};
    // bytes R..k-1 of the current beat moved to the MSB side
    keep_shl   = keep_eff << res;
    in_shl     = s01_axis_tdata << (8 * res);
    // {pending B-R bytes of previous beat, top R bytes of current beat}
    pass_data  = (hold << (8 * res)) | (s01_axis_tdata >> (8 * (DATA_BYTE_WD - res)));
    pass_keep  = ({DATA_BYTE_WD{1'b1}} << res) | (keep_eff >> (DATA_BYTE_WD - res));
    flush_data = hold << (8 * res);
  end

  // Control FSM with registered output beat and length-channel ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_rdy       <= 1'b0;
      drop_cnt      <= '0;
      res           <= '0;
      hold          <= '0;
      flush_keep    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // a consumed beat frees the register; an emit below re-arms it
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          len_rdy <= 1'b1;
          if (len_rdy && s00_axis_tvalid) begin
            len_rdy  <= 1'b0;
            drop_cnt <= len_d;
            res      <= len_r;
            state    <= (len_d != '0) ? DROP : ALIGN;
          end
        end

        DROP: begin
          if (in_fire) begin
            if (s01_axis_tlast) begin
              state   <= IDLE;
              len_rdy <= 1'b1;
            end else begin
              drop_cnt <= drop_cnt - 1'b1;
              if (drop_cnt == LEN_WD'(1)) begin
                state <= ALIGN;
              end
            end
          end
        end

        ALIGN: begin
          if (in_fire) begin
            hold <= s01_axis_tdata;
            if (res == '0) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= s01_axis_tdata;
              m_axis_tkeep  <= keep_eff;
              m_axis_tlast  <= s01_axis_tlast;
              if (s01_axis_tlast) begin
                state   <= IDLE;
                len_rdy <= 1'b1;
              end else begin
                state <= PASS;
              end
            end else if (!s01_axis_tlast) begin
              state <= PASS;
            end else begin
              // short last beat: emit only if bytes survive the residual strip
              if (keep_shl != '0) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= in_shl;
                m_axis_tkeep  <= keep_shl;
                m_axis_tlast  <= 1'b1;
              end
              state   <= IDLE;
              len_rdy <= 1'b1;
            end
          end
        end

        PASS: begin
          if (in_fire) begin
            hold          <= s01_axis_tdata;
            m_axis_tvalid <= 1'b1;
            if (res == '0) begin
              m_axis_tdata <= s01_axis_tdata;
              m_axis_tkeep <= keep_eff;
              m_axis_tlast <= s01_axis_tlast;
              if (s01_axis_tlast) begin
                state   <= IDLE;
                len_rdy <= 1'b1;
              end
            end else begin
              m_axis_tdata <= pass_data;
              m_axis_tkeep <= pass_keep;
              m_axis_tlast <= s01_axis_tlast && (keep_shl == '0);
              if (s01_axis_tlast) begin
                if (keep_shl != '0) begin
                  flush_keep <= keep_shl;
                  state      <= FLUSH;
                end else begin
                  state   <= IDLE;
                  len_rdy <= 1'b1;
                end
              end
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= flush_data;
            m_axis_tkeep  <= flush_keep;
            m_axis_tlast  <= 1'b1;
            state         <= IDLE;
            len_rdy       <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          len_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_strip_header
// Purpose  : Scoreboard bench for axi_stream_strip_header (B=4). A byte-level
//            model strips N bytes from each packet and re-chunks the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_strip_header;

  localparam int DATA_WD = 32;
  localparam int B       = 4;
  localparam int LEN_WD  = 8;

  typedef struct {
    logic [DATA_WD-1:0] data;
    logic [B-1:0]       keep;
    logic               last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s00_axis_tvalid = 1'b0;
  logic [LEN_WD-1:0] s00_axis_tdata = '0;
  logic              s00_axis_tready;
  logic              s01_axis_tvalid = 1'b0;
  logic [DATA_WD-1:0] s01_axis_tdata = '0;
  logic [B-1:0]      s01_axis_tkeep = '0;
  logic              s01_axis_tlast = 1'b0;
  logic              s01_axis_tready;
  logic              m_axis_tvalid;
  logic [DATA_WD-1:0] m_axis_tdata;
  logic [B-1:0]      m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;

  int    checks   = 0;
  int    failures = 0;
  int    ready_pct = 70;
  bit    mon_en   = 1'b0;
  bit    use_gaps = 1'b0;
  beat_t exp_q[$];
  beat_t stim_q[$];

  axi_stream_strip_header #(.DATA_WD(DATA_WD), .DATA_BYTE_WD(B), .LEN_WD(LEN_WD)) dut (
    .clk(clk), .rst(rst),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tdata(s01_axis_tdata), .s01_axis_tkeep(s01_axis_tkeep),
    .s01_axis_tlast(s01_axis_tlast), .s01_axis_tready(s01_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // Reference model: flatten stim_q to bytes, drop n, re-chunk into B-byte beats
  task automatic push_expected(input int n);
    logic [7:0] bq[$];
    beat_t e;
    bq = {};
    foreach (stim_q[i]) begin
      for (int j = 0; j < B; j++) begin
        if (!stim_q[i].last || stim_q[i].keep[B-1-j])
          bq.push_back(stim_q[i].data[DATA_WD-1-8*j -: 8]);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (bq.size() > 0) void'(bq.pop_front());
    end
    while (bq.size() > 0) begin
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < B; j++) begin
        if (bq.size() > 0) begin
          e.data[DATA_WD-1-8*j -: 8] = bq.pop_front();
          e.keep[B-1-j] = 1'b1;
        end
      end
      e.last = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_len(input int n);
    bit hs = 1'b0;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = LEN_WD'(n);
    for (int t = 0; t < 2000 && !hs; t++) begin
      @(negedge clk);
      hs = s00_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!hs) timeout_fail("len_accept");
    s00_axis_tvalid = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    bit hs = 1'b0;
    if (use_gaps) begin
      s01_axis_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    s01_axis_tvalid = 1'b1;
    s01_axis_tdata  = b.data;
    s01_axis_tkeep  = b.keep;
    s01_axis_tlast  = b.last;
    for (int t = 0; t < 2000 && !hs; t++) begin
      @(negedge clk);
      hs = s01_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!hs) timeout_fail("beat_accept");
    s01_axis_tvalid = 1'b0;
  endtask

  task automatic send_packet(input int n);
    push_expected(n);
    send_len(n);
    foreach (stim_q[i]) send_beat(stim_q[i]);
  endtask

  task automatic build_directed();
    beat_t b;
    stim_q = {};
    b.data = 32'hA0A1A2A3; b.keep = 4'b1111; b.last = 1'b0; stim_q.push_back(b);
    b.data = 32'hB0B1B2B3; b.keep = 4'b1111; b.last = 1'b0; stim_q.push_back(b);
    b.data = 32'hC0C1EEEE; b.keep = 4'b1100; b.last = 1'b1; stim_q.push_back(b);
  endtask

  // random packet; non-last keeps are random to exercise the "treated as full" rule
  task automatic build_random();
    beat_t b;
    int len, nb, k;
    stim_q = {};
    len = $urandom_range(1, 24);
    nb  = (len + B - 1) / B;
    for (int i = 0; i < nb; i++) begin
      b.data = $urandom;
      b.last = (i == nb - 1);
      if (b.last) begin
        k = len - (nb - 1) * B;
        b.keep = 4'hF << (B - k);
      end else begin
        b.keep = 4'($urandom);
      end
      stim_q.push_back(b);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) timeout_fail("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: compares each output handshake against the scoreboard, and checks stall stability
  logic               stalled = 1'b0;
  logic [DATA_WD-1:0] s_data;
  logic [B-1:0]       s_keep;
  logic               s_last;
  always @(negedge clk) begin
    beat_t e;
    logic [DATA_WD-1:0] mask;
    if (!mon_en || rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", 64'(m_axis_tdata), 64'(s_data));
        chk("stall_keep", 64'(m_axis_tkeep), 64'(s_keep));
        chk("stall_last", 64'(m_axis_tlast), 64'(s_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h/%b required=none", m_axis_tdata, m_axis_tkeep);
        end else begin
          e = exp_q.pop_front();
          for (int j = 0; j < B; j++) mask[8*j +: 8] = {8{e.keep[j]}};
          chk("out_data", 64'(m_axis_tdata & mask), 64'(e.data & mask));
          chk("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
          chk("out_last", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      s_data  = m_axis_tdata;
      s_keep  = m_axis_tkeep;
      s_last  = m_axis_tlast;
    end
  end

  initial begin
    beat_t b;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_s00_tready", 64'(s00_axis_tready), 64'd0);
    chk("rst_s01_tready", 64'(s01_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // directed packets: pass-through, flush path, drop+realign, whole-packet drop
    build_directed(); send_packet(0);
    build_directed(); send_packet(1);
    build_directed(); send_packet(6);
    build_directed(); send_packet(12);
    build_directed(); send_packet(3);
    wait_drain();

    // random packets and random N, with input gaps
    use_gaps = 1'b1;
    for (int p = 0; p < 30; p++) begin
      build_random();
      send_packet($urandom_range(0, 28));
    end
    for (int p = 0; p < 10; p++) begin
      build_random();
      send_packet(2);
    end
    wait_drain();

    // reset mid-packet while in PASS
    use_gaps = 1'b0;
    mon_en   = 1'b0;
    send_len(1);
    b.data = 32'h11223344; b.keep = 4'hF; b.last = 1'b0; send_beat(b);
    b.data = 32'h55667788; b.keep = 4'hF; b.last = 1'b0; send_beat(b);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("mid_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("mid_rst_s00_tready", 64'(s00_axis_tready), 64'd0);
    chk("mid_rst_s01_tready", 64'(s01_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle_len_ready", 64'(s00_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    build_directed(); send_packet(1);
    wait_drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
